// File: rtl/booth_pkg.sv
// Shared types and Booth recode constants for the sequential Booth multiplier.
// Define BOOTH_RADIX4_EN to build the radix-4 (modified Booth) datapath.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] R2_ADD = 2'b01;
  localparam logic [1:0] R2_SUB = 2'b10;

  localparam logic [2:0] R4_P1A = 3'b001;
  localparam logic [2:0] R4_P1B = 3'b010;
  localparam logic [2:0] R4_P2  = 3'b011;
  localparam logic [2:0] R4_M2  = 3'b100;
  localparam logic [2:0] R4_M1A = 3'b101;
  localparam logic [2:0] R4_M1B = 3'b110;

  // Bits retired per step; also the accumulator guard width.
`ifdef BOOTH_RADIX4_EN
  localparam int SHIFT = 2;
`else
  localparam int SHIFT = 1;
`endif

endpackage

// File: rtl/booth_step.sv
// One Booth recode/add/shift iteration (radix-2, or radix-4 with
// BOOTH_RADIX4_EN). Purely combinational.
module booth_step
  import booth_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int AW    = WIDTH + SHIFT
) (
  input  logic [AW-1:0]    acc,
  input  logic [WIDTH-1:0] q,
  input  logic             qm1,
  input  logic [WIDTH-1:0] m,
  output logic [AW-1:0]    acc_nx,
  output logic [WIDTH-1:0] q_nx,
  output logic             qm1_nx
);

  logic [AW-1:0] mx;
  logic [AW-1:0] sum;

  // Guard bits keep -(-2^(W-1)) and +-2M representable.
  assign mx = {{SHIFT{m[WIDTH-1]}}, m};

`ifdef BOOTH_RADIX4_EN
  logic [AW-1:0] m2;
  assign m2 = mx << 1;

  always_comb begin
    sum = acc;
    case ({q[1:0], qm1})
      R4_P1A, R4_P1B: sum = acc + mx;
      R4_P2:          sum = acc + m2;
      R4_M2:          sum = acc - m2;
      R4_M1A, R4_M1B: sum = acc - mx;
      default:        sum = acc;
    endcase
  end

  assign acc_nx = {{2{sum[AW-1]}}, sum[AW-1:2]};
  assign q_nx   = {sum[1:0], q[WIDTH-1:2]};
  assign qm1_nx = q[1];
`else
  always_comb begin
    sum = acc;
    case ({q[0], qm1})
      R2_ADD:  sum = acc + mx;
      R2_SUB:  sum = acc - mx;
      default: sum = acc;
    endcase
  end

  assign acc_nx = {sum[AW-1], sum[AW-1:1]};
  assign q_nx   = {sum[0], q[WIDTH-1:1]};
  assign qm1_nx = q[0];
`endif

endmodule

// File: rtl/booth_mul_ctrl.sv
// Sequential signed Booth multiplier: IDLE/RUN/DONE control around booth_step.
// BOOTH_RADIX4_EN selects radix-4 steps (WIDTH/2 iterations).
module booth_mul_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int AW     = WIDTH + SHIFT;
  localparam int NSTEPS = WIDTH / SHIFT;
  localparam int CW     = $clog2(NSTEPS + 1);
  localparam logic [CW-1:0] LAST = CW'(NSTEPS - 1);

  state_t           state;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_nx;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] mplier_nx;
  logic [WIDTH-1:0] mcand;
  logic             qm1;
  logic             qm1_nx;
  logic [CW-1:0]    cnt;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc    (acc),
    .q      (mplier),
    .qm1    (qm1),
    .m      (mcand),
    .acc_nx (acc_nx),
    .q_nx   (mplier_nx),
    .qm1_nx (qm1_nx)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      HI     <= '0;
      LO     <= '0;
      cnt    <= '0;
      acc    <= '0;
      mplier <= '0;
      mcand  <= '0;
      qm1    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc    <= '0;
            mplier <= Q;
            mcand  <= M;
            qm1    <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_nx;
          mplier <= mplier_nx;
          qm1    <= qm1_nx;
          cnt    <= cnt + 1'b1;
          // Results are latched straight from the final step.
          if (cnt == LAST) begin
            HI    <= acc_nx[WIDTH-1:0];
            LO    <= mplier_nx;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Self-checking bench for booth_mul_ctrl: vector table, corner sequences,
// and random back-to-back products against a signed-multiply model.
module tb_booth_mul_ctrl;

`ifdef BOOTH_RADIX4_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] M_i;
  logic [31:0] Q_i;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  booth_mul_ctrl #(.WIDTH(32)) dut (
    .clock (clock),
    .clear (clear),
    .start (start),
    .M     (M_i),
    .Q     (Q_i),
    .busy  (busy),
    .done  (done),
    .HI    (HI),
    .LO    (LO)
  );

  typedef struct {
    logic [31:0] m;
    logic [31:0] q;
    logic [63:0] prod;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a,
                                          input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  // Launch one op, then watch cycles 1.. until done (bounded).
  task automatic run_op(input logic [31:0] m, input logic [31:0] q,
                        output logic [63:0] prod, output int lat,
                        output bit stable, output bit busy_ok);
    logic [31:0] h0;
    logic [31:0] l0;
    @(negedge clock);
    start = 1'b1;
    M_i   = m;
    Q_i   = q;
    @(posedge clock);
    #1;
    start   = 1'b0;
    M_i     = $urandom;
    Q_i     = $urandom;
    lat     = 0;
    stable  = 1'b1;
    busy_ok = 1'b1;
    h0      = HI;
    l0      = LO;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clock);
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
      if (HI !== h0 || LO !== l0) stable = 1'b0;
    end
    prod = {HI, LO};
  endtask

  vec_t        vecs[6];
  logic [63:0] prod;
  int          lat;
  bit          stable;
  bit          busy_ok;
  int          ndone;
  logic [63:0] dprod;
  int          rnd_bad;

  initial begin
    vecs[0] = '{32'd3,         32'd5,         64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFF9, 32'd6,         64'hFFFF_FFFF_FFFF_FFD6};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[4] = '{32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
    vecs[5] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};

    clear = 1'b1;
    start = 1'b1;
    M_i   = 32'h1234_5678;
    Q_i   = 32'h0BAD_F00D;
    repeat (3) @(posedge clock);
    #1;
    clear = 1'b0;
    start = 1'b0;
    chk("reset_state", {30'd0, busy, done, HI, LO}, 64'd0);
    @(negedge clock);
    chk("reset_idle_busy", {63'd0, busy}, 64'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].m, vecs[i].q, prod, lat, stable, busy_ok);
      chk($sformatf("vec%0d_product", i), prod, vecs[i].prod);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
      chk($sformatf("vec%0d_busy", i), {63'd0, busy_ok}, 64'd1);
      chk($sformatf("vec%0d_hold", i), {63'd0, stable}, 64'd1);
      @(negedge clock);
      chk($sformatf("vec%0d_idle", i), {62'd0, busy, done}, 64'd0);
    end

    // start asserted mid-RUN must not restart or recapture
    @(negedge clock);
    start = 1'b1;
    M_i   = 32'd3;
    Q_i   = 32'd5;
    @(posedge clock);
    #1;
    start = 1'b0;
    ndone = 0;
    dprod = '0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clock);
      if (done) begin
        ndone++;
        dprod = {HI, LO};
      end
      if (c >= 3 && c <= 20) begin
        start = 1'b1;
        M_i   = 32'd2;
        Q_i   = 32'd2;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("ignore_start_pulses", 64'(ndone), 64'd1);
    chk("ignore_start_result", dprod, 64'd15);

    // clear in cycle 10 of RUN abandons the op
    @(negedge clock);
    start = 1'b1;
    M_i   = 32'd3;
    Q_i   = 32'd5;
    @(posedge clock);
    #1;
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (done) ndone++;
    end
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    @(negedge clock);
    chk("clear_outputs", {30'd0, busy, done, HI, LO}, 64'd0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (done) ndone++;
    end
    chk("clear_no_done", 64'(ndone), 64'd0);
    run_op(32'd3, 32'd5, prod, lat, stable, busy_ok);
    chk("after_clear_product", prod, 64'd15);
    chk("after_clear_latency", 64'(lat), 64'(LAT));

    // random back-to-back operations
    rnd_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      if (i % 8 == 0) a = 32'h8000_0000;
      if (i % 11 == 0) b = 32'h8000_0000;
      run_op(a, b, prod, lat, stable, busy_ok);
      checks++;
      if (prod !== ref_mul(a, b) || lat != LAT || !stable || !busy_ok) begin
        failures++;
        rnd_bad++;
        if (rnd_bad <= 10)
          $display("FAIL rand%0d M=%h Q=%h actual=%h lat=%0d required=%h lat=%0d",
                   i, a, b, prod, lat, ref_mul(a, b), LAT);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_mul_ctrl.md
BOOTH_MUL_CTRL -- requirements
Module: booth_mul_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width in bits (even, >= 4).
REQ-002 SHALL have port: clock  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port: clear  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port: M  input  WIDTH  signed multiplicand, captured on the accepted start edge.
REQ-006 SHALL have port: Q  input  WIDTH  signed multiplier, captured on the accepted start edge.
REQ-007 SHALL have port: busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-008 SHALL have port: done  output  1  one-cycle pulse marking HI/LO valid.
REQ-009 SHALL have port: HI  output  WIDTH  upper half of the signed 2*WIDTH product.
REQ-010 SHALL have port: LO  output  WIDTH  lower half of the signed 2*WIDTH product.
REQ-011 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-013 SHALL, in IDLE with start=1, load the accumulator A=0, the multiplier register from Q, the extra bit q_m1=0 and the multiplicand register from M, clear the step counter, and go to RUN.
REQ-014 SHALL, in RUN, perform one radix-2 Booth step per cycle on {Q[0],q_m1}: 01 -> A+M, 10 -> A-M, 00/11 -> no add; then arithmetic right shift of {A,Q,q_m1} by 1.
REQ-015 SHALL perform exactly WIDTH steps in RUN, then go to DONE.
REQ-016 SHALL, on entry to DONE, register HI=A and LO=Q; done=1 for that single cycle; then go to IDLE.
REQ-017 SHALL give latency with start sampled at edge 0: busy=1 in cycles 1..WIDTH+1, and done=1 in cycle WIDTH+1 (cycle 33 for WIDTH=32).
REQ-018 SHALL ignore start in RUN and DONE: no restart and no operand capture.
REQ-019 SHALL hold HI/LO from the last completed operation until the next DONE; they SHALL NOT change during RUN.
REQ-020 SHALL perform all arithmetic modulo 2^WIDTH on A; the product SHALL equal the exact signed product for all inputs, including M = Q = -2^(WIDTH-1).
REQ-021 SHALL accept back-to-back operations: start=1 in the IDLE cycle after done begins a new operation.

Reset
REQ-022 SHALL, when clear=1 at an edge, force state=IDLE, busy=0, done=0, HI=0, LO=0, counter=0 and A=0, overriding start.
REQ-023 SHALL, if clear asserts mid-RUN, abandon the operation with no done pulse.

Configuration
REQ-024 SHALL, with macro BOOTH_RADIX4_EN defined, use radix-4 (modified Booth) steps on {Q[1],Q[0],q_m1}: 0, +-M, +-2M, then arithmetic right shift by 2, over WIDTH/2 steps; done then falls in cycle WIDTH/2+1 (17 for WIDTH=32).
REQ-025 SHALL, without BOOTH_RADIX4_EN, use radix-2 exactly as in REQ-014/REQ-017; results SHALL be identical in both builds.
REQ-026 SHALL, in the radix-4 build, use a WIDTH+2-bit internal accumulator so that +-2M cannot overflow.

Structure
REQ-027 SHALL place the state enum (IDLE/RUN/DONE) and the Booth recode constants in the shared package booth_pkg.
REQ-028 SHALL have a combinational sub-module booth_step that computes one recode/add/shift iteration (radix selected by the macro); the FSM and counter SHALL stay in booth_mul_ctrl.

Verification
REQ-029 SHALL cover: M=3, Q=5, start at edge 0 -> done in cycle 33 (17 radix-4), HI=0x00000000, LO=0x0000000F.
REQ-030 SHALL cover: M=-7, Q=6 -> HI=0xFFFFFFFF, LO=0xFFFFFFD6.
REQ-031 SHALL cover: M=Q=0x80000000 -> HI=0x40000000, LO=0x00000000.
REQ-032 SHALL cover: start=1 with M=2, Q=2 during RUN of 3*5 -> result still 15, exactly one done pulse.
REQ-033 SHALL cover: clear at cycle 10 of RUN -> next cycle busy=0, HI=LO=0, no done; a new start then completes normally.
REQ-034 SHALL cover: 1000 random signed pairs back-to-back -> {HI,LO} equals the 64-bit signed reference product each time.
